// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Purpose  : Shared widths, limits and request/response records for the
//            pipelined memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_DATA_W  = 16;
  localparam int MEM_ADDR_W  = 16;
  localparam int MAX_LATENCY = 8;

  // One in-flight request as it travels down the pipeline
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_req_t;

  // Registered response presented to the CPU
  typedef struct packed {
    logic                  valid;
    logic                  wr;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] data;
  } mem_resp_t;

endpackage
`default_nettype wire

// File: rtl/mem_req_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_pipe
// Purpose  : DEPTH-deep shift register of requests; valid bits clear on an
//            asynchronous reset so in-flight requests are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_pipe
  import mem_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  input  mem_req_t in_req,
  output mem_req_t out_req,
  output logic     any_valid
);

  mem_req_t stg [DEPTH];

  // Shift every request one stage per cycle; reset empties all stages
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stg[i] <= '0;
      end
    end else begin
      stg[0] <= in_req;
      for (int i = 1; i < DEPTH; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  // Any stage holding a request counts as in flight
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid = any_valid | stg[i].valid;
    end
  end

  assign out_req = stg[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Purpose  : Fixed-latency pipelined memory. Each request is answered exactly
//            LATENCY cycles later, in request order; the array is accessed
//            on the edge that loads the response registers.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
  import mem_pkg::*;
#(
  parameter int    LATENCY   = 4,
  parameter int    WORD_AW   = 10,
  parameter string INIT_FILE = ""
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_en,
  input  logic                  req_wr,
  input  logic [MEM_ADDR_W-1:0] req_addr,
  input  logic [MEM_DATA_W-1:0] req_data,
  output logic                  resp_valid,
  output logic                  resp_wr,
  output logic [MEM_ADDR_W-1:0] resp_addr,
  output logic [MEM_DATA_W-1:0] resp_data,
  output logic                  busy
);

  mem_req_t               in_req;
  mem_req_t               acc_req;
  mem_resp_t              resp_q;
  logic                   pipe_busy;
  logic                   mem_we;
  logic [WORD_AW-1:0]     acc_idx;
  logic [MEM_DATA_W-1:0]  mem [2**WORD_AW];

  // Build the request record; payload is zeroed when idle so undriven
  // wr/addr/data never enter the pipeline
  always_comb begin
    in_req = '0;
    if (req_en) begin
      in_req.valid = 1'b1;
      in_req.wr    = req_wr;
      in_req.addr  = req_addr & ~16'h0001;
      in_req.data  = req_wr ? req_data : '0;
    end
  end

  if (LATENCY == 1) begin : g_bypass
    assign acc_req   = in_req;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    mem_req_pipe #(
      .DEPTH (LATENCY - 1)
    ) u_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_req    (in_req),
      .out_req   (acc_req),
      .any_valid (pipe_busy)
    );
  end

  assign acc_idx = acc_req.addr[WORD_AW:1];
  // rst_n gates the write so a request sampled during reset never commits
  assign mem_we  = acc_req.valid & acc_req.wr & rst_n;

  // Array write port: commits at the access point, contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[acc_idx] <= acc_req.data;
    end
  end

  // Response registers: read data or echoed write data; hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_q <= '0;
    end else begin
      resp_q.valid <= acc_req.valid;
      if (acc_req.valid) begin
        resp_q.wr   <= acc_req.wr;
        resp_q.addr <= acc_req.addr;
        resp_q.data <= acc_req.wr ? acc_req.data : mem[acc_idx];
      end
    end
  end

  assign resp_valid = resp_q.valid;
  assign resp_wr    = resp_q.wr;
  assign resp_addr  = resp_q.addr;
  assign resp_data  = resp_q.data;
  assign busy       = pipe_busy | resp_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Purpose  : Directed bench for mem_responder at LATENCY=4 and LATENCY=1.
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_en, req_wr;
  logic [15:0] req_addr, req_data;
  logic        resp_valid, resp_wr, busy;
  logic [15:0] resp_addr, resp_data;

  logic        l1_en, l1_wr;
  logic [15:0] l1_addr, l1_data;
  logic        l1_resp_valid, l1_resp_wr, l1_busy;
  logic [15:0] l1_resp_addr, l1_resp_data;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.LATENCY(4), .WORD_AW(10), .INIT_FILE("")) dut (
    .clk(clk), .rst_n(rst_n),
    .req_en(req_en), .req_wr(req_wr), .req_addr(req_addr), .req_data(req_data),
    .resp_valid(resp_valid), .resp_wr(resp_wr), .resp_addr(resp_addr),
    .resp_data(resp_data), .busy(busy)
  );

  mem_responder #(.LATENCY(1), .WORD_AW(10), .INIT_FILE("")) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_en(l1_en), .req_wr(l1_wr), .req_addr(l1_addr), .req_data(l1_data),
    .resp_valid(l1_resp_valid), .resp_wr(l1_resp_wr), .resp_addr(l1_resp_addr),
    .resp_data(l1_resp_data), .busy(l1_busy)
  );

  task automatic drv(input logic wr, input logic [15:0] a, input logic [15:0] d);
    req_en = 1'b1; req_wr = wr; req_addr = a; req_data = d;
  endtask

  task automatic idle();
    req_en = 1'b0; req_wr = 1'bx; req_addr = 'x; req_data = 'x;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    l1_en = 1'b0; l1_wr = 1'b0; l1_addr = '0; l1_data = '0;
    repeat (2) @(negedge clk);
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset resp_valid got %b want 0", resp_valid); end
    checks++; if (resp_wr !== 1'b0) begin errors++; $display("FAIL reset resp_wr got %b want 0", resp_wr); end
    checks++; if (resp_addr !== 16'h0000) begin errors++; $display("FAIL reset resp_addr got %h want 0000", resp_addr); end
    checks++; if (resp_data !== 16'h0000) begin errors++; $display("FAIL reset resp_data got %h want 0000", resp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b want 0", busy); end
    checks++; if (l1_resp_valid !== 1'b0 || l1_busy !== 1'b0) begin errors++; $display("FAIL reset l1 valid/busy got %b/%b want 0/0", l1_resp_valid, l1_busy); end
    rst_n = 1'b1;
  endtask

  // Write 0xBEEF @0x0010 in c0, read @0x0011 in c5
  task automatic test_write_read();
    logic exp_v;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
      exp_v = (c == 4) || (c == 9);
      checks++; if (resp_valid !== exp_v) begin errors++; $display("FAIL wr_rd valid c%0d got %b want %b", c, resp_valid, exp_v); end
      if (c == 1) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL wr_rd busy c1 got %b want 1", busy); end
      end
      if (c == 4) begin
        checks++; if (resp_wr !== 1'b1) begin errors++; $display("FAIL wr_rd wr c4 got %b want 1", resp_wr); end
        checks++; if (resp_addr !== 16'h0010) begin errors++; $display("FAIL wr_rd addr c4 got %h want 0010", resp_addr); end
        checks++; if (resp_data !== 16'hBEEF) begin errors++; $display("FAIL wr_rd data c4 got %h want beef", resp_data); end
      end
      if (c == 9) begin
        checks++; if (resp_wr !== 1'b0) begin errors++; $display("FAIL wr_rd wr c9 got %b want 0", resp_wr); end
        checks++; if (resp_addr !== 16'h0010) begin errors++; $display("FAIL wr_rd addr c9 got %h want 0010", resp_addr); end
        checks++; if (resp_data !== 16'hBEEF) begin errors++; $display("FAIL wr_rd data c9 got %h want beef", resp_data); end
      end
      if (c == 10) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wr_rd busy c10 got %b want 0", busy); end
      end
      case (c)
        0:       drv(1'b1, 16'h0010, 16'hBEEF);
        5:       drv(1'b0, 16'h0011, 16'h0000);
        default: idle();
      endcase
    end
  endtask

  // W1111, R, W2222, R all @0x20 in consecutive cycles
  task automatic test_back_to_back();
    logic [15:0] exp_d [4];
    logic        exp_w [4];
    exp_d[0] = 16'h1111; exp_d[1] = 16'h1111; exp_d[2] = 16'h2222; exp_d[3] = 16'h2222;
    exp_w[0] = 1'b1; exp_w[1] = 1'b0; exp_w[2] = 1'b1; exp_w[3] = 1'b0;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 4 && c <= 7) begin
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b valid c%0d got %b want 1", c, resp_valid); end
        checks++; if (resp_wr !== exp_w[c-4]) begin errors++; $display("FAIL b2b wr c%0d got %b want %b", c, resp_wr, exp_w[c-4]); end
        checks++; if (resp_data !== exp_d[c-4]) begin errors++; $display("FAIL b2b data c%0d got %h want %h", c, resp_data, exp_d[c-4]); end
      end
      if (c == 8) begin
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b idle c8 valid/busy got %b/%b want 0/0", resp_valid, busy); end
      end
      case (c)
        0:       drv(1'b1, 16'h0020, 16'h1111);
        1:       drv(1'b0, 16'h0020, 16'h0000);
        2:       drv(1'b1, 16'h0020, 16'h2222);
        3:       drv(1'b0, 16'h0020, 16'h0000);
        default: idle();
      endcase
    end
  endtask

  // Reads in c0 and c2 only; the gap must show up as a missing response
  task automatic test_bubbles();
    logic exp_v;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 3) begin
        exp_v = (c == 4) || (c == 6);
        checks++; if (resp_valid !== exp_v) begin errors++; $display("FAIL bubble valid c%0d got %b want %b", c, resp_valid, exp_v); end
        if (exp_v) begin
          checks++; if (resp_data !== 16'h2222) begin errors++; $display("FAIL bubble data c%0d got %h want 2222", c, resp_data); end
        end
        exp_v = (c != 7);
        checks++; if (busy !== exp_v) begin errors++; $display("FAIL bubble busy c%0d got %b want %b", c, busy, exp_v); end
      end
      if (c == 0 || c == 2) drv(1'b0, 16'h0020, 16'h0000);
      else idle();
    end
  endtask

  // 0x0804 aliases word 2 with WORD_AW=10
  task automatic test_wrap();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++; if (resp_valid !== 1'b1 || resp_addr !== 16'h0004) begin errors++; $display("FAIL wrap wr c4 valid/addr got %b/%h want 1/0004", resp_valid, resp_addr); end
      end
      if (c == 5) begin
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL wrap valid c5 got %b want 1", resp_valid); end
        checks++; if (resp_addr !== 16'h0804) begin errors++; $display("FAIL wrap addr c5 got %h want 0804", resp_addr); end
        checks++; if (resp_data !== 16'hA5A5) begin errors++; $display("FAIL wrap data c5 got %h want a5a5", resp_data); end
      end
      case (c)
        0:       drv(1'b1, 16'h0004, 16'hA5A5);
        1:       drv(1'b0, 16'h0804, 16'h0000);
        default: idle();
      endcase
    end
  endtask

  // Preload 0x0001 @0x30, start a 0x7777 write, reset two cycles later
  task automatic test_reset_midflight();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      if (c == 7) begin
        rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid immediate valid/busy got %b/%b want 0/0", resp_valid, busy); end
      end
      if (c >= 8 && c <= 10) begin
        checks++; if (resp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid hold c%0d valid/busy got %b/%b want 0/0", c, resp_valid, busy); end
      end
      if (c == 12) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid busy c12 got %b want 1", busy); end
      end
      if (c == 15) begin
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rstmid valid c15 got %b want 1", resp_valid); end
        checks++; if (resp_data !== 16'h0001) begin errors++; $display("FAIL rstmid data c15 got %h want 0001", resp_data); end
      end
      if (c == 16) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid busy c16 got %b want 0", busy); end
      end
      if (c == 10) rst_n = 1'b1;
      case (c)
        0:       drv(1'b1, 16'h0030, 16'h0001);
        5:       drv(1'b1, 16'h0030, 16'h7777);
        9:       drv(1'b1, 16'h0030, 16'h9999);
        11:      drv(1'b0, 16'h0030, 16'h0000);
        default: idle();
      endcase
    end
  endtask

  // LATENCY=1: alternating write/read every cycle, answered next cycle
  task automatic test_latency1();
    int          i;
    logic        ew;
    logic [15:0] ea, ed;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (c >= 1 && c <= 10) begin
        i  = c - 1;
        ew = (i % 2 == 0);
        ea = 16'h0050 + 16'((i - (i % 2)) * 2);
        ed = 16'h0100 + 16'(i - (i % 2));
        checks++; if (l1_resp_valid !== 1'b1) begin errors++; $display("FAIL l1 valid c%0d got %b want 1", c, l1_resp_valid); end
        checks++; if (l1_resp_wr !== ew) begin errors++; $display("FAIL l1 wr c%0d got %b want %b", c, l1_resp_wr, ew); end
        checks++; if (l1_resp_addr !== ea) begin errors++; $display("FAIL l1 addr c%0d got %h want %h", c, l1_resp_addr, ea); end
        checks++; if (l1_resp_data !== ed) begin errors++; $display("FAIL l1 data c%0d got %h want %h", c, l1_resp_data, ed); end
      end else begin
        checks++; if (l1_resp_valid !== 1'b0 || l1_busy !== 1'b0) begin errors++; $display("FAIL l1 idle c%0d valid/busy got %b/%b want 0/0", c, l1_resp_valid, l1_busy); end
      end
      if (c <= 9) begin
        l1_en   = 1'b1;
        l1_wr   = (c % 2 == 0);
        l1_addr = 16'h0050 + 16'((c - (c % 2)) * 2);
        l1_data = (c % 2 == 0) ? 16'h0100 + 16'(c) : 16'h0000;
      end else begin
        l1_en = 1'b0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_back_to_back();
    test_bubbles();
    test_wrap();
    test_reset_midflight();
    test_latency1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
